// File: rtl/pc_gen_btb.sv
// Fetch PC generator with optional branch target buffer and 2-bit predictor.
// Define PCGEN_BTB_EN to build the BTB; otherwise fetch is static not-taken.
module pc_gen_btb #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  branch_validE,
  input  logic                  branch_takenE,
  input  logic                  jalrinsE,
  input  logic [DATA_WIDTH-1:0] pcE,
  input  logic [DATA_WIDTH-1:0] pc_targetE,
  input  logic [DATA_WIDTH-1:0] alu_outE,
  input  logic                  pred_takenE,
  input  logic [DATA_WIDTH-1:0] pred_targetE,
  output logic [DATA_WIDTH-1:0] pcF,
  output logic [DATA_WIDTH-1:0] pc_plus4F,
  output logic                  pred_takenF,
  output logic [DATA_WIDTH-1:0] pred_targetF,
  output logic                  mispredictE
);

  logic [DATA_WIDTH-1:0] actual_target;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  unused_alu_lsb;

  assign pc_plus4F      = pcF + DATA_WIDTH'(4);
  assign actual_target  = jalrinsE ? {alu_outE[DATA_WIDTH-1:1], 1'b0} : pc_targetE;
  assign unused_alu_lsb = alu_outE[0];

  // A wrong target on a correctly-predicted taken branch is still a redirect.
  assign mispredictE = branch_validE &
                       ((branch_takenE != pred_takenE) |
                        (branch_takenE & (pred_targetE != actual_target)));

  // Redirect outranks the stall so a flush is never lost while fetch is held.
  always_comb begin
    if (mispredictE)      pc_next = branch_takenE ? actual_target : pcE + DATA_WIDTH'(4);
    else if (!en)         pc_next = pcF;
    else if (pred_takenF) pc_next = pred_targetF;
    else                  pc_next = pc_plus4F;
  end

  always_ff @(posedge clk) begin
    if (rst) pcF <= RESET_PC;
    else     pcF <= pc_next;
  end

`ifdef PCGEN_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = DATA_WIDTH - IW - 2;

  typedef struct packed {
    logic                  valid;
    logic [TW-1:0]         tag;
    logic [DATA_WIDTH-1:0] target;
    logic [1:0]            ctr;
  } btb_entry_t;

  btb_entry_t    btb [BTB_ENTRIES];
  btb_entry_t    f_ent, e_ent;
  logic [IW-1:0] f_idx, e_idx;
  logic [TW-1:0] f_tag, e_tag;
  logic          e_hit;

  assign f_idx = pcF[IW+1:2];
  assign f_tag = pcF[DATA_WIDTH-1:IW+2];
  assign e_idx = pcE[IW+1:2];
  assign e_tag = pcE[DATA_WIDTH-1:IW+2];
  assign f_ent = btb[f_idx];
  assign e_ent = btb[e_idx];
  assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

  // Lookup reads the array before this edge's update lands.
  assign pred_takenF  = f_ent.valid && (f_ent.tag == f_tag) && f_ent.ctr[1];
  assign pred_targetF = pred_takenF ? f_ent.target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'd1};
    end else if (branch_validE) begin
      if (e_hit) begin
        if (branch_takenE) begin
          btb[e_idx].target <= actual_target;
          if (e_ent.ctr != 2'd3) btb[e_idx].ctr <= e_ent.ctr + 2'd1;
        end else if (e_ent.ctr != 2'd0) begin
          btb[e_idx].ctr <= e_ent.ctr - 2'd1;
        end
      end else if (branch_takenE) begin
        // Direct-mapped: a taken miss evicts whatever aliases to this slot.
        btb[e_idx] <= '{valid: 1'b1, tag: e_tag, target: actual_target, ctr: 2'd2};
      end
    end
  end
`else
  assign pred_takenF  = 1'b0;
  assign pred_targetF = '0;
`endif

endmodule

// File: tb/tb_pc_gen_btb.sv
// Randomized + directed bench for pc_gen_btb against an array-based predictor model.
module tb_pc_gen_btb;
  localparam int          DW    = 32;
  localparam int          N     = 16;
  localparam logic [31:0] RPC   = 32'h100;

  logic          clk = 1'b0;
  logic          rst, en, branch_validE, branch_takenE, jalrinsE, pred_takenE;
  logic [DW-1:0] pcE, pc_targetE, alu_outE, pred_targetE;
  logic [DW-1:0] pcF, pc_plus4F, pred_targetF;
  logic          pred_takenF, mispredictE;

  int checks = 0;
  int errors = 0;

  pc_gen_btb #(.DATA_WIDTH(DW), .BTB_ENTRIES(N), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en), .branch_validE(branch_validE),
    .branch_takenE(branch_takenE), .jalrinsE(jalrinsE), .pcE(pcE),
    .pc_targetE(pc_targetE), .alu_outE(alu_outE), .pred_takenE(pred_takenE),
    .pred_targetE(pred_targetE), .pcF(pcF), .pc_plus4F(pc_plus4F),
    .pred_takenF(pred_takenF), .pred_targetF(pred_targetF), .mispredictE(mispredictE)
  );

  always #5 clk = ~clk;

  // Reference model: a table of N slots addressed by word index, tag is the rest.
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int slot(input logic [31:0] pc); return int'((pc / 4) % N); endfunction
  function automatic logic [31:0] tagof(input logic [31:0] pc); return pc / (4 * N); endfunction

  function automatic logic m_ptaken(input logic [31:0] pc);
`ifdef PCGEN_BTB_EN
    int s = slot(pc);
    return m_valid[s] && (m_tag[s] == tagof(pc)) && (m_ctr[s] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[slot(pc)] : 32'h0;
  endfunction

  function automatic logic [31:0] m_actual();
    return jalrinsE ? (alu_outE & ~32'h1) : pc_targetE;
  endfunction

  function automatic logic m_mispredict();
    return branch_validE && ((branch_takenE != pred_takenE) ||
                             (branch_takenE && (pred_targetE != m_actual())));
  endfunction

  // Compute the model's next state from current inputs, then cross the edge.
  task automatic advance();
    logic [31:0] nxt;
    int s;
    if (rst)                 nxt = RPC;
    else if (m_mispredict()) nxt = branch_takenE ? m_actual() : pcE + 32'd4;
    else if (!en)            nxt = m_pc;
    else if (m_ptaken(m_pc)) nxt = m_ptarget(m_pc);
    else                     nxt = m_pc + 32'd4;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else if (branch_validE) begin
      s = slot(pcE);
      if (m_valid[s] && m_tag[s] == tagof(pcE)) begin
        if (branch_takenE) begin m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1; m_tgt[s] = m_actual(); end
        else               m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end else if (branch_takenE) begin
        m_valid[s] = 1; m_tag[s] = tagof(pcE); m_tgt[s] = m_actual(); m_ctr[s] = 2;
      end
    end
    @(posedge clk); #1;
    m_pc = nxt;
  endtask

  task automatic clear_e();
    branch_validE = 0; branch_takenE = 0; jalrinsE = 0; pred_takenE = 0;
    pcE = 0; pc_targetE = 0; alu_outE = 0; pred_targetE = 0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    branch_validE = 1; branch_takenE = tk; jalrinsE = 0; pcE = pc;
    pc_targetE = tgt; pred_takenE = ptk; pred_targetE = ptgt; alu_outE = 0;
  endtask

  // Steer fetch to addr with a not-taken mispredict at addr-4 (never allocates).
  task automatic redirect_to(input logic [31:0] addr);
    drive_br(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    advance();
    clear_e();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10C;
    rst = 1; en = 0; clear_e();
    advance();
    rst = 0; #1;
    checks++;
    if (pcF !== RPC || pred_takenF !== 1'b0 || pred_targetF !== 32'h0) begin
      errors++;
      $display("FAIL reset: pcF=%h pt=%b ptgt=%h, want pcF=%h pt=0 ptgt=0", pcF, pred_takenF, pred_targetF, RPC);
    end
    en = 1;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (pcF !== exp_pc[i]) begin
        errors++; $display("FAIL reset_seq%0d: pcF=%h want %h", i, pcF, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    redirect_to(32'h20);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      advance();
      checks++;
      if (pcF !== 32'h20 || pc_plus4F !== 32'h24) begin
        errors++; $display("FAIL stall%0d: pcF=%h p4=%h want 20/24", i, pcF, pc_plus4F);
      end
    end
    en = 1;
  endtask

  task automatic test_first_taken();
    drive_br(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    checks++;
    if (mispredictE !== 1'b1) begin errors++; $display("FAIL first_taken_mis: got %b want 1", mispredictE); end
    advance(); clear_e(); #1;
    checks++;
    if (pcF !== 32'h80) begin errors++; $display("FAIL first_taken_redirect: pcF=%h want 80", pcF); end
    redirect_to(32'h40);
`ifdef PCGEN_BTB_EN
    checks++;
    if (pred_takenF !== 1'b1 || pred_targetF !== 32'h80) begin
      errors++; $display("FAIL first_taken_pred: pt=%b ptgt=%h want 1/80", pred_takenF, pred_targetF);
    end
    advance();
    checks++;
    if (pcF !== 32'h80) begin errors++; $display("FAIL first_taken_follow: pcF=%h want 80", pcF); end
`else
    checks++;
    if (pred_takenF !== 1'b0 || pred_targetF !== 32'h0) begin
      errors++; $display("FAIL static_pred: pt=%b ptgt=%h want 0/0", pred_takenF, pred_targetF);
    end
    advance();
    checks++;
    if (pcF !== 32'h44) begin errors++; $display("FAIL static_follow: pcF=%h want 44", pcF); end
`endif
  endtask

  task automatic test_jalr();
    en = 0;
    branch_validE = 1; branch_takenE = 1; jalrinsE = 1; pcE = 32'h300;
    alu_outE = 32'h1235; pc_targetE = 32'h9990; pred_takenE = 0; pred_targetE = 0;
    #1;
    checks++;
    if (mispredictE !== 1'b1) begin errors++; $display("FAIL jalr_mis: got %b want 1", mispredictE); end
    advance(); clear_e(); #1;
    checks++;
    if (pcF !== 32'h1234) begin errors++; $display("FAIL jalr_redirect: pcF=%h want 1234", pcF); end
    en = 1;
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) begin
      drive_br(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); advance();
    end
    drive_br(32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    checks++;
    if (mispredictE !== 1'b1) begin errors++; $display("FAIL hyst_mis: got %b want 1", mispredictE); end
    advance(); clear_e(); #1;
    checks++;
    if (pcF !== 32'h44) begin errors++; $display("FAIL hyst_redirect: pcF=%h want 44", pcF); end
    redirect_to(32'h40);
    checks++;
`ifdef PCGEN_BTB_EN
    if (pred_takenF !== 1'b1) begin errors++; $display("FAIL hyst_still_taken: pt=%b want 1", pred_takenF); end
`else
    if (pred_takenF !== 1'b0) begin errors++; $display("FAIL hyst_static: pt=%b want 0", pred_takenF); end
`endif
    drive_br(32'h40, 1'b0, 32'h80, 1'b1, 32'h80); advance(); clear_e();
    redirect_to(32'h40);
    checks++;
    if (pred_takenF !== 1'b0) begin errors++; $display("FAIL hyst_flip: pt=%b want 0", pred_takenF); end
  endtask

  task automatic test_alias();
    logic [31:0] alias_pc;
    alias_pc = 32'h40 + 4 * N;
    drive_br(32'h40, 1'b1, 32'h200, 1'b0, 32'h0); advance();
    drive_br(32'h40, 1'b1, 32'h200, 1'b0, 32'h0); advance();
    drive_br(alias_pc, 1'b1, 32'h300, 1'b0, 32'h0); advance(); clear_e();
    redirect_to(32'h40);
    checks++;
    if (pred_takenF !== 1'b0 || pred_targetF !== 32'h0) begin
      errors++; $display("FAIL alias_evict: pt=%b ptgt=%h want 0/0", pred_takenF, pred_targetF);
    end
    redirect_to(alias_pc);
    checks++;
    if (pred_takenF !== m_ptaken(alias_pc) || pred_targetF !== m_ptarget(alias_pc)) begin
      errors++; $display("FAIL alias_new: pt=%b ptgt=%h want %b/%h", pred_takenF, pred_targetF,
                         m_ptaken(alias_pc), m_ptarget(alias_pc));
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 79) == 0);
      en            = ($urandom_range(0, 3) != 0);
      branch_validE = ($urandom_range(0, 1) == 1);
      branch_takenE = ($urandom_range(0, 1) == 1);
      jalrinsE      = ($urandom_range(0, 4) == 0);
      pcE           = 32'($urandom_range(0, 47)) * 4;
      pc_targetE    = 32'($urandom_range(0, 63)) * 4;
      alu_outE      = 32'($urandom_range(0, 511));
      pred_takenE   = ($urandom_range(0, 1) == 1);
      a             = jalrinsE ? (alu_outE & ~32'h1) : pc_targetE;
      pred_targetE  = ($urandom_range(0, 2) != 0) ? a : 32'($urandom_range(0, 63)) * 4;
      #1;
      checks++;
      if (pcF !== m_pc || pc_plus4F !== m_pc + 32'd4 || pred_takenF !== m_ptaken(m_pc) ||
          pred_targetF !== m_ptarget(m_pc) || mispredictE !== m_mispredict()) begin
        errors++;
        $display("FAIL random%0d: pcF=%h p4=%h pt=%b ptgt=%h mis=%b want %h/%h/%b/%h/%b", c,
                 pcF, pc_plus4F, pred_takenF, pred_targetF, mispredictE,
                 m_pc, m_pc + 32'd4, m_ptaken(m_pc), m_ptarget(m_pc), m_mispredict());
      end
      advance();
    end
    rst = 0; clear_e();
  endtask

  initial begin
    m_pc = 32'h0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; end
    test_reset();
    test_stall();
    test_first_taken();
    test_jalr();
    test_hysteresis();
    test_alias();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
